pixel_serializer: RTL
=====================

// Module: pixel_serializer
// PURPOSE
//  Parametrised pixel serialiser and successor to the fixed 16-bit video shift register.
//  - Double-buffered: a holding register plus an active shifter.
//  - Source handshake is valid/ready, so fetch logic can prefetch a word ahead.
//  - Emits one pixel of 1/2/4/8 bits per enable_i strobe, MSB-first.
//  - Sits between display fetch and palette lookup.
//  - Flags starvation with a sticky underflow bit.
// PARAMETERS
//  DATA_W   16  word width; power of two, >= MAX_BPP
//  MAX_BPP  8   widest pixel; power of two, 1..DATA_W; LOG2_BPP = clog2(MAX_BPP) derived
// PORTS
//  dotclk_i          in   1         dot clock; all state updates on rising edge
//  reset_i           in   1         synchronous, active-high reset
//  dat_i             in   DATA_W    fetched pixel word
//  dat_valid_i       in   1         dat_i valid
//  dat_ready_o       out  1         holding register can accept a word
//  bpp_i             in   2         depth code: 0=1, 1=2, 2=4, 3=8 bpp (codes > LOG2_BPP clamp to MAX_BPP)
//  enable_i          in   1         pixel strobe: consume/advance one pixel
//  flush_i           in   1         discard shifter and holding contents (e.g. h-blank)
//  clear_underflow_i in   1         clear sticky underflow
//  pix_o             out  MAX_BPP   current pixel, right-justified, upper bits zero
//  pix_valid_o       out  1         pix_o holds a real pixel
//  pix_last_o        out  1         pix_o is the last pixel of its word
//  underflow_o       out  1         sticky: enable_i seen while no pixel valid
// BEHAVIOUR
//  State: sh[DATA_W], hold[DATA_W], hold_full, rem (pixels left in sh, clog2(DATA_W)+1 bits), bpp_l.
//  Reset (while reset_i=1): all state 0; dat_ready_o=0, pix_valid_o=0, pix_o=0, pix_last_o=0, underflow_o=0.
//  Combinational outputs:
//   dat_ready_o = ~hold_full & ~reset_i & ~flush_i.
//   pix_valid_o = (rem!=0); pix_last_o = (rem==1).
//   pix_o = pix_valid_o ? sh[DATA_W-1 -: (1<<bpp_l)], zero-extended : 0.
//  Accept: dat_valid_i & dat_ready_o -> hold<=dat_i, hold_full<=1. Zero-latency bypass to sh is not allowed.
//  Load sh from hold (sh<=hold, bpp_l<=bpp_i, rem<=DATA_W>>bpp_i, hold_full<=0) when either:
//   (a) rem==0 & hold_full (auto-prime; enable_i not required; no pixel consumed), or
//   (b) enable_i & rem==1 & hold_full (back-to-back reload; no bubble).
//  Shift: enable_i & rem>1 -> sh<=sh<<(1<<bpp_l), rem<=rem-1.
//  Drain: enable_i & rem==1 & ~hold_full -> rem<=0.
//  Depth latch: bpp_i is sampled only at a load; changes mid-word take effect at the next word.
//  Underflow: enable_i & rem==0 -> underflow_o<=1; pix_o stays 0, no state advance.
//   A same-cycle auto-prime does not prevent the underflow.
//  Underflow clear: clear_underflow_i clears underflow_o; simultaneous set and clear -> set wins.
//  Flush: flush_i -> rem<=0, hold_full<=0, sh<=0 (bpp_l unchanged).
//   No accept that cycle; enable_i ignored (no underflow).
//   Priority: reset_i > flush_i > normal operation.
//  Hold refill: hold_full cleared by a load -> dat_ready_o=1 the next cycle.
//   With a same-cycle source, 8bpp/16-bit sustains one pixel per cycle.
//  Reset mid-word: all data lost; the first accepted word after release is pixel 0.
// TESTING
//  1 Reset: reset_i=1 for 2 cycles with dat_valid_i=1 -> dat_ready_o=0, pix_valid_o=0;
//    no word accepted; after release dat_ready_o=1.
//  2 1bpp: bpp_i=0, push 16'hA5C3, enable_i=1 continuous -> pix_o[0] = 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1;
//    pix_last_o on 16th; then pix_valid_o=0.
//  3 8bpp streaming: source offers 16'h1234, 16'h5678 whenever ready, enable_i=1 from first valid pixel ->
//    pix_o 8'h12, 8'h34, 8'h56, 8'h78 on 4 consecutive cycles, no bubble.
//  4 Mode change: 4bpp word 16'hF00F; set bpp_i=0 after 1st pixel -> pixels F,0,0,F (4 pixels);
//    next word 16'h8000 yields 16 1-bit pixels, first=1.
//  5 Underflow: enable_i=1 while empty -> underflow_o=1 next cycle, pix_o=0.
//    Holds until clear_underflow_i; clear with a same-cycle underflow -> stays 1.
//  6 Flush: mid-word with hold_full, flush_i=1 with dat_valid_i=1 -> next cycle pix_valid_o=0,
//    dat_ready_o=1, no word accepted, underflow_o unchanged.

Source files
------------

// File: rtl/pixel_serializer_if.sv
// Source-side word handshake for pixel_serializer.
// The display fetch logic drives the master side; the serializer is the slave.
interface pixel_serializer_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0] dat;        // fetched pixel word
    logic              dat_valid;  // dat holds a word on offer
    logic              dat_ready;  // serializer holding register can take it

    modport master (
        output dat,
        output dat_valid,
        input  dat_ready
    );

    modport slave (
        input  dat,
        input  dat_valid,
        output dat_ready
    );
endinterface

// File: rtl/pixel_serializer.sv
// Double-buffered pixel serializer sitting between display fetch and palette lookup.
// A holding register takes one word ahead over a valid/ready handshake; an active
// shifter emits one 1/2/4/8-bit pixel per enable_i strobe, MSB-first. The pixel
// depth is latched when a word moves into the shifter, so depth changes apply at
// word boundaries. A sticky underflow flag records strobes that found no pixel.
module pixel_serializer #(
    parameter int DATA_W  = 16,
    parameter int MAX_BPP = 8
) (
    input  logic               dotclk_i,
    input  logic               reset_i,
    pixel_serializer_if.slave  src,
    input  logic [1:0]         bpp_i,
    input  logic               enable_i,
    input  logic               flush_i,
    input  logic               clear_underflow_i,
    output logic [MAX_BPP-1:0] pix_o,
    output logic               pix_valid_o,
    output logic               pix_last_o,
    output logic               underflow_o
);

    localparam int LOG2_BPP = $clog2(MAX_BPP);
    localparam int REM_W    = $clog2(DATA_W) + 1;

    localparam logic [REM_W-1:0] REM_ZERO = '0;
    localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);

    // Active shifter, holding register and their bookkeeping.
    logic [DATA_W-1:0] sh_q,        sh_d;
    logic [DATA_W-1:0] hold_q,      hold_d;
    logic              hold_full_q, hold_full_d;
    logic [REM_W-1:0]  rem_q,       rem_d;
    logic [1:0]        bpp_l_q,     bpp_l_d;
    logic              underflow_q, underflow_d;

    logic              dat_ready;
    logic              accept;
    logic              load;
    logic [1:0]        bpp_eff;
    logic [MAX_BPP-1:0] pix_top;

    // Depth codes wider than the widest supported pixel collapse to MAX_BPP.
    always_comb begin
        if (32'(bpp_i) > LOG2_BPP) begin
            bpp_eff = 2'(LOG2_BPP);
        end else begin
            bpp_eff = bpp_i;
        end
    end

    // The holding register is writable only when empty and not being flushed.
    assign dat_ready     = ~hold_full_q & ~reset_i & ~flush_i;
    assign src.dat_ready = dat_ready;
    assign accept        = src.dat_valid & dat_ready;

    // Prime an idle shifter, or reload on the strobe that consumes the last pixel.
    assign load = hold_full_q &
                  ((rem_q == REM_ZERO) | (enable_i & (rem_q == REM_ONE)));

    // Pixel is the top (1 << bpp_l) bits of the shifter, right-justified.
    assign pix_top     = sh_q[DATA_W-1 -: MAX_BPP];
    assign pix_valid_o = (rem_q != REM_ZERO);
    assign pix_last_o  = (rem_q == REM_ONE);
    assign pix_o       = pix_valid_o ? (pix_top >> (MAX_BPP - (1 << bpp_l_q))) : '0;
    assign underflow_o = underflow_q;

    // Next-state: flush, then load/shift/drain of the shifter, refill, underflow.
    always_comb begin
        // NOTE: every _d takes its _q value first so no path through this block
        // leaves a variable unassigned and infers a latch.
        sh_d        = sh_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rem_d       = rem_q;
        bpp_l_d     = bpp_l_q;
        underflow_d = underflow_q;

        if (flush_i) begin
            // Discard everything in flight; the strobe is ignored this cycle.
            sh_d        = '0;
            rem_d       = '0;
            hold_full_d = 1'b0;
            if (clear_underflow_i) begin
                underflow_d = 1'b0;
            end
        end else begin
            if (load) begin
                sh_d        = hold_q;
                bpp_l_d     = bpp_eff;
                rem_d       = REM_W'(DATA_W >> bpp_eff);
                hold_full_d = 1'b0;
            end else if (enable_i && (rem_q > REM_ONE)) begin
                sh_d  = sh_q << (1 << bpp_l_q);
                rem_d = rem_q - REM_ONE;
            end else if (enable_i && (rem_q == REM_ONE)) begin
                rem_d = '0;
            end

            // Accept only happens into an empty holding register, so it never
            // collides with a load out of it.
            if (accept) begin
                hold_d      = src.dat;
                hold_full_d = 1'b1;
            end

            // A strobe with nothing to show sets the flag even if a prime
            // happens on the same edge; setting beats clearing.
            if (enable_i && (rem_q == REM_ZERO)) begin
                underflow_d = 1'b1;
            end else if (clear_underflow_i) begin
                underflow_d = 1'b0;
            end
        end
    end

    // State registers with synchronous reset to an empty, idle serializer.
    always_ff @(posedge dotclk_i) begin
        // NOTE: non-blocking assignments so every register updates from the
        // same pre-edge values regardless of statement order.
        if (reset_i) begin
            sh_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rem_q       <= '0;
            bpp_l_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rem_q       <= rem_d;
            bpp_l_q     <= bpp_l_d;
            underflow_q <= underflow_d;
        end
    end

endmodule
